// File: rtl/npc_axi_pkg.sv
// Shared AXI-Lite response codes, channel FSM states and byte-lane helper
// for the instruction/data backing-store slave.
package npc_axi_pkg;

  localparam int unsigned WORD_W = 32;
  localparam int unsigned STRB_W = WORD_W / 8;
  localparam int unsigned RESP_W = 2;

  localparam logic [RESP_W-1:0] RESP_OKAY   = 2'b00;
  localparam logic [RESP_W-1:0] RESP_SLVERR = 2'b10;

  typedef enum logic [1:0] {R_IDLE, R_WAIT, R_RESP} rd_state_t;
  typedef enum logic [1:0] {W_IDLE, W_WAIT, W_RESP} wr_state_t;

  // Replace only the byte lanes whose strobe is set.
  function automatic logic [WORD_W-1:0] merge_strb(
    input logic [WORD_W-1:0] old_word,
    input logic [WORD_W-1:0] new_word,
    input logic [STRB_W-1:0] strb
  );
    logic [WORD_W-1:0] res;
    res = old_word;
    for (int i = 0; i < int'(STRB_W); i++) begin
      if (strb[i]) res[8*i +: 8] = new_word[8*i +: 8];
    end
    return res;
  endfunction

endpackage

// File: rtl/axi_lat_counter.sv
// Loadable down-counter; done_c is high while the count sits at zero.
module axi_lat_counter #(
  parameter int unsigned W = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic         done_c
);

  logic [W-1:0] cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (cnt != '0) begin
      cnt <= cnt - W'(1);
    end
  end

  assign done_c = (cnt == '0);

endmodule

// File: rtl/axi_lite_sram_slave.sv
// AXI4-Lite slave backed by a word-addressed SRAM, with independent read and
// write channel FSMs and a fixed response latency on each channel.
module axi_lite_sram_slave
  import npc_axi_pkg::*;
#(
  parameter int unsigned       ADDR_W      = 32,
  parameter int unsigned       DATA_W      = 32,
  parameter int unsigned       DEPTH_WORDS = 4096,
  parameter logic [ADDR_W-1:0] BASE_ADDR   = 32'h8000_0000,
  parameter int unsigned       READ_LAT    = 2,
  parameter int unsigned       WRITE_LAT   = 2
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [ADDR_W-1:0]   araddr,
  input  logic                arvalid,
  output logic                arready,
  output logic [DATA_W-1:0]   rdata,
  output logic [1:0]          rresp,
  output logic                rvalid,
  input  logic                rready,
  input  logic [ADDR_W-1:0]   awaddr,
  input  logic                awvalid,
  output logic                awready,
  input  logic [DATA_W-1:0]   wdata,
  input  logic [DATA_W/8-1:0] wstrb,
  input  logic                wvalid,
  output logic                wready,
  output logic [1:0]          bresp,
  output logic                bvalid,
  input  logic                bready
);

  localparam int unsigned     SW     = DATA_W / 8;
  localparam int unsigned     IDX_W  = $clog2(DEPTH_WORDS);
  localparam int unsigned     RCNT_W = $clog2(READ_LAT + 1);
  localparam int unsigned     WCNT_W = $clog2(WRITE_LAT + 1);
  localparam logic [ADDR_W:0] SPAN   = (ADDR_W+1)'(4 * DEPTH_WORDS);

  logic [DATA_W-1:0] mem [DEPTH_WORDS];

  // Read channel state
  rd_state_t         rd_state, rd_state_n;
  logic [ADDR_W-1:0] raddr_q, raddr_n;
  logic              arready_n, rvalid_n;
  logic [DATA_W-1:0] rdata_n;
  logic [1:0]        rresp_n;
  logic              rd_load_c, rd_done_c;
  logic [ADDR_W-1:0] rd_off_c;
  logic              rd_hit_c;
  logic [IDX_W-1:0]  rd_idx_c;
  logic [DATA_W-1:0] mem_rdata_c;

  // Write channel state
  wr_state_t         wr_state, wr_state_n;
  logic [ADDR_W-1:0] waddr_q, waddr_n;
  logic [DATA_W-1:0] wdata_q, wdata_n;
  logic [SW-1:0]     wstrb_q, wstrb_n;
  logic              aw_got, aw_got_n, w_got, w_got_n;
  logic              awready_n, wready_n, bvalid_n;
  logic [1:0]        bresp_n;
  logic              wr_load_c, wr_done_c, wr_commit_c;
  logic [ADDR_W-1:0] wr_off_c;
  logic              wr_hit_c;
  logic [IDX_W-1:0]  wr_idx_c;

  // Unsigned subtraction makes addresses below the base wrap to huge offsets,
  // so a single upper-bound compare covers both ends of the window.
  assign rd_off_c    = raddr_q - BASE_ADDR;
  assign rd_hit_c    = ((ADDR_W+1)'(rd_off_c) < SPAN);
  assign rd_idx_c    = IDX_W'(rd_off_c >> 2);
  assign mem_rdata_c = mem[rd_idx_c];

  assign wr_off_c    = waddr_q - BASE_ADDR;
  assign wr_hit_c    = ((ADDR_W+1)'(wr_off_c) < SPAN);
  assign wr_idx_c    = IDX_W'(wr_off_c >> 2);

  axi_lat_counter #(.W(RCNT_W)) u_rd_cnt (
    .clk      (clk),
    .rst      (rst),
    .load     (rd_load_c),
    .load_val (RCNT_W'(READ_LAT - 1)),
    .done_c   (rd_done_c)
  );

  axi_lat_counter #(.W(WCNT_W)) u_wr_cnt (
    .clk      (clk),
    .rst      (rst),
    .load     (wr_load_c),
    .load_val (WCNT_W'(WRITE_LAT - 1)),
    .done_c   (wr_done_c)
  );

  // Read channel next-state and output values
  always_comb begin
    rd_state_n = rd_state;
    raddr_n    = raddr_q;
    arready_n  = arready;
    rvalid_n   = rvalid;
    rdata_n    = rdata;
    rresp_n    = rresp;
    rd_load_c  = 1'b0;
    case (rd_state)
      R_IDLE: begin
        arready_n = 1'b1;
        if (arvalid && arready) begin
          raddr_n    = araddr;
          rd_load_c  = 1'b1;
          arready_n  = 1'b0;
          rd_state_n = R_WAIT;
        end
      end
      R_WAIT: begin
        if (rd_done_c) begin
          rdata_n    = rd_hit_c ? mem_rdata_c : '0;
          rresp_n    = rd_hit_c ? RESP_OKAY : RESP_SLVERR;
          rvalid_n   = 1'b1;
          rd_state_n = R_RESP;
        end
      end
      R_RESP: begin
        if (rready) begin
          rvalid_n   = 1'b0;
          arready_n  = 1'b1;
          rd_state_n = R_IDLE;
        end
      end
      default: rd_state_n = R_IDLE;
    endcase
  end

  // Write channel next-state and output values; AW and W are captured independently
  always_comb begin
    wr_state_n  = wr_state;
    waddr_n     = waddr_q;
    wdata_n     = wdata_q;
    wstrb_n     = wstrb_q;
    aw_got_n    = aw_got;
    w_got_n     = w_got;
    awready_n   = awready;
    wready_n    = wready;
    bvalid_n    = bvalid;
    bresp_n     = bresp;
    wr_load_c   = 1'b0;
    wr_commit_c = 1'b0;
    case (wr_state)
      W_IDLE: begin
        if (awvalid && awready) begin
          waddr_n  = awaddr;
          aw_got_n = 1'b1;
        end
        if (wvalid && wready) begin
          wdata_n = wdata;
          wstrb_n = wstrb;
          w_got_n = 1'b1;
        end
        awready_n = !aw_got_n;
        wready_n  = !w_got_n;
        if (aw_got_n && w_got_n) begin
          wr_load_c  = 1'b1;
          wr_state_n = W_WAIT;
        end
      end
      W_WAIT: begin
        if (wr_done_c) begin
          wr_commit_c = 1'b1;
          bresp_n     = wr_hit_c ? RESP_OKAY : RESP_SLVERR;
          bvalid_n    = 1'b1;
          wr_state_n  = W_RESP;
        end
      end
      W_RESP: begin
        if (bready) begin
          bvalid_n   = 1'b0;
          awready_n  = 1'b1;
          wready_n   = 1'b1;
          aw_got_n   = 1'b0;
          w_got_n    = 1'b0;
          wr_state_n = W_IDLE;
        end
      end
      default: wr_state_n = W_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_state <= R_IDLE;
      raddr_q  <= '0;
      arready  <= 1'b0;
      rvalid   <= 1'b0;
      rdata    <= '0;
      rresp    <= RESP_OKAY;
      wr_state <= W_IDLE;
      waddr_q  <= '0;
      wdata_q  <= '0;
      wstrb_q  <= '0;
      aw_got   <= 1'b0;
      w_got    <= 1'b0;
      awready  <= 1'b0;
      wready   <= 1'b0;
      bvalid   <= 1'b0;
      bresp    <= RESP_OKAY;
    end else begin
      rd_state <= rd_state_n;
      raddr_q  <= raddr_n;
      arready  <= arready_n;
      rvalid   <= rvalid_n;
      rdata    <= rdata_n;
      rresp    <= rresp_n;
      wr_state <= wr_state_n;
      waddr_q  <= waddr_n;
      wdata_q  <= wdata_n;
      wstrb_q  <= wstrb_n;
      aw_got   <= aw_got_n;
      w_got    <= w_got_n;
      awready  <= awready_n;
      wready   <= wready_n;
      bvalid   <= bvalid_n;
      bresp    <= bresp_n;
    end
  end

  // Storage is not reset; a commit coinciding with rst is dropped
  always_ff @(posedge clk) begin
    if (!rst && wr_commit_c && wr_hit_c) begin
      mem[wr_idx_c] <= merge_strb(mem[wr_idx_c], wdata_q, wstrb_q);
    end
  end

endmodule

// File: tb/tb_axi_lite_sram_slave.sv
// Directed table-driven bench for axi_lite_sram_slave plus hand-written
// sequences for split AW/W, backpressure, collisions and mid-operation reset.
module tb_axi_lite_sram_slave;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] araddr, awaddr, wdata, rdata;
  logic        arvalid, arready, rvalid, rready;
  logic        awvalid, awready, wvalid, wready, bvalid, bready;
  logic [3:0]  wstrb;
  logic [1:0]  rresp, bresp;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  axi_lite_sram_slave dut (
    .clk     (clk),
    .rst     (rst),
    .araddr  (araddr),
    .arvalid (arvalid),
    .arready (arready),
    .rdata   (rdata),
    .rresp   (rresp),
    .rvalid  (rvalid),
    .rready  (rready),
    .awaddr  (awaddr),
    .awvalid (awvalid),
    .awready (awready),
    .wdata   (wdata),
    .wstrb   (wstrb),
    .wvalid  (wvalid),
    .wready  (wready),
    .bresp   (bresp),
    .bvalid  (bvalid),
    .bready  (bready)
  );

  typedef struct {
    logic        wr;
    logic [31:0] addr;
    logic [31:0] data;
    logic [3:0]  strb;
    logic [31:0] exp_data;
    logic [1:0]  exp_resp;
  } vec_t;

  vec_t vecs[14];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, got, exp);
    end
  endtask

  task automatic do_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                          output logic [1:0] resp, output int lat);
    logic ah, wh;
    int   n;
    awaddr = a; wdata = d; wstrb = s;
    awvalid = 1'b1; wvalid = 1'b1;
    n = 0;
    while ((awvalid || wvalid) && n < 20) begin
      ah = awvalid && awready;
      wh = wvalid && wready;
      tick();
      if (ah) awvalid = 1'b0;
      if (wh) wvalid = 1'b0;
      n++;
    end
    check("wr_addr_data_accepted", 32'(awvalid || wvalid), 32'd0);
    awvalid = 1'b0; wvalid = 1'b0;
    lat = 0;
    while (!bvalid && lat < 20) begin
      tick();
      lat++;
    end
    resp = bresp;
    bready = 1'b1;
    tick();
    bready = 1'b0;
  endtask

  task automatic do_read(input logic [31:0] a, output logic [31:0] d,
                         output logic [1:0] resp, output int lat);
    int n;
    araddr = a;
    arvalid = 1'b1;
    n = 0;
    while (!arready && n < 20) begin
      tick();
      n++;
    end
    tick();
    arvalid = 1'b0;
    check("rd_addr_accepted", 32'(n < 20), 32'd1);
    lat = 0;
    while (!rvalid && lat < 20) begin
      tick();
      lat++;
    end
    d = rdata;
    resp = rresp;
    rready = 1'b1;
    tick();
    rready = 1'b0;
  endtask

  logic [31:0] got_d, bp_d;
  logic [1:0]  got_r, bp_r;
  int          lat, n;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

  initial begin
    vecs[0]  = '{1'b1, 32'h8000_0010, 32'hDEAD_BEEF, 4'hF, 32'h0,         2'b00};
    vecs[1]  = '{1'b0, 32'h8000_0010, 32'h0,         4'h0, 32'hDEAD_BEEF, 2'b00};
    vecs[2]  = '{1'b1, 32'h8000_0020, 32'h1122_3344, 4'hF, 32'h0,         2'b00};
    vecs[3]  = '{1'b1, 32'h8000_0020, 32'hAABB_CCDD, 4'h5, 32'h0,         2'b00};
    vecs[4]  = '{1'b0, 32'h8000_0020, 32'h0,         4'h0, 32'h11BB_33DD, 2'b00};
    vecs[5]  = '{1'b1, 32'h8000_3FFC, 32'hCAFE_F00D, 4'hF, 32'h0,         2'b00};
    vecs[6]  = '{1'b1, 32'h8000_4000, 32'h1234_5678, 4'hF, 32'h0,         2'b10};
    vecs[7]  = '{1'b0, 32'h8000_3FFC, 32'h0,         4'h0, 32'hCAFE_F00D, 2'b00};
    vecs[8]  = '{1'b0, 32'h7FFF_FFFC, 32'h0,         4'h0, 32'h0,         2'b10};
    vecs[9]  = '{1'b1, 32'h8000_0020, 32'hFFFF_FFFF, 4'h0, 32'h0,         2'b00};
    vecs[10] = '{1'b0, 32'h8000_0022, 32'h0,         4'h0, 32'h11BB_33DD, 2'b00};
    vecs[11] = '{1'b0, 32'h8000_4000, 32'h0,         4'h0, 32'h0,         2'b10};
    vecs[12] = '{1'b1, 32'h8000_0000, 32'h0BAD_F00D, 4'hA, 32'h0,         2'b00};
    vecs[13] = '{1'b1, 32'h8000_0040, 32'h0101_0101, 4'hF, 32'h0,         2'b00};

    rst = 1'b1;
    araddr = '0; arvalid = 1'b0; rready = 1'b0;
    awaddr = '0; awvalid = 1'b0; wdata = '0; wstrb = '0; wvalid = 1'b0; bready = 1'b0;
    repeat (3) tick();
    check("reset_outputs", {rdata[23:0], arready, awready, wready, rvalid, bvalid, rresp, bresp[0]},
          32'h0);
    check("reset_rdata_bresp", {rdata[31:24], 22'h0, bresp}, 32'h0);
    rst = 1'b0;
    tick();
    check("ready_after_reset", {29'h0, arready, awready, wready}, 32'h7);

    // Table of directed transactions, each with latency 2
    foreach (vecs[i]) begin
      if (vecs[i].wr) begin
        do_write(vecs[i].addr, vecs[i].data, vecs[i].strb, got_r, lat);
        check($sformatf("v%0d_bresp", i), 32'(got_r), 32'(vecs[i].exp_resp));
        check($sformatf("v%0d_wlat", i), 32'(lat), 32'd2);
      end else begin
        do_read(vecs[i].addr, got_d, got_r, lat);
        check($sformatf("v%0d_rdata", i), got_d, vecs[i].exp_data);
        check($sformatf("v%0d_rresp", i), 32'(got_r), 32'(vecs[i].exp_resp));
        check($sformatf("v%0d_rlat", i), 32'(lat), 32'd2);
      end
    end

    // Split AW/W: AW three cycles ahead of W; latency counts from W capture
    awaddr = 32'h8000_0030; awvalid = 1'b1;
    tick();
    awvalid = 1'b0;
    check("split_ready_after_aw", {30'h0, awready, wready}, 32'h1);
    tick();
    tick();
    check("split_no_early_bvalid", 32'(bvalid), 32'd0);
    wdata = 32'h5566_7788; wstrb = 4'hF; wvalid = 1'b1;
    tick();
    wvalid = 1'b0;
    lat = 0;
    while (!bvalid && lat < 20) begin tick(); lat++; end
    check("split_wlat", 32'(lat), 32'd2);
    check("split_bresp", 32'(bresp), 32'd0);
    bready = 1'b1; tick(); bready = 1'b0;
    check("split_ready_restored", {30'h0, awready, wready}, 32'h3);
    do_read(32'h8000_0030, got_d, got_r, lat);
    check("split_readback", got_d, 32'h5566_7788);
    do_read(32'h8000_0000, got_d, got_r, lat);
    check("strb_word0_readback", got_d & 32'hFF00_FF00, 32'h0B00_F000);

    // Backpressure: response held stable while rready is low
    araddr = 32'h8000_0010; arvalid = 1'b1;
    tick();
    arvalid = 1'b0;
    n = 0;
    while (!rvalid && n < 20) begin tick(); n++; end
    bp_d = rdata; bp_r = rresp;
    check("bp_rdata", bp_d, 32'hDEAD_BEEF);
    for (int k = 0; k < 5; k++) begin
      check($sformatf("bp_hold%0d", k), {rdata[27:0], rvalid, rresp, arready},
            {bp_d[27:0], 1'b1, bp_r, 1'b0});
      tick();
    end
    rready = 1'b1; tick(); rready = 1'b0;
    check("bp_release", {30'h0, arready, rvalid}, 32'h2);

    // Same-edge read/write collision returns the pre-write word
    araddr = 32'h8000_0040; awaddr = 32'h8000_0040; wdata = 32'h0202_0202; wstrb = 4'hF;
    arvalid = 1'b1; awvalid = 1'b1; wvalid = 1'b1;
    tick();
    arvalid = 1'b0; awvalid = 1'b0; wvalid = 1'b0;
    n = 0;
    while (!(rvalid && bvalid) && n < 20) begin tick(); n++; end
    check("coll_both_valid_same_cycle", 32'(n), 32'd2);
    check("coll_old_data", rdata, 32'h0101_0101);
    rready = 1'b1; bready = 1'b1; tick(); rready = 1'b0; bready = 1'b0;
    do_read(32'h8000_0040, got_d, got_r, lat);
    check("coll_new_data", got_d, 32'h0202_0202);

    // Reset on the commit edge drops the write
    awaddr = 32'h8000_0040; wdata = 32'h0303_0303; wstrb = 4'hF;
    awvalid = 1'b1; wvalid = 1'b1;
    tick();
    awvalid = 1'b0; wvalid = 1'b0;
    tick();
    rst = 1'b1;
    tick();
    check("rstw_no_bvalid", 32'(bvalid), 32'd0);
    rst = 1'b0;
    tick();
    do_read(32'h8000_0040, got_d, got_r, lat);
    check("rstw_not_committed", got_d, 32'h0202_0202);

    // Reset during R_WAIT: no response, readies low in reset then back high
    araddr = 32'h8000_0010; arvalid = 1'b1;
    tick();
    arvalid = 1'b0;
    rst = 1'b1;
    tick();
    check("rstr_in_reset", {28'h0, arready, awready, wready, rvalid}, 32'h0);
    tick();
    rst = 1'b0;
    tick();
    check("rstr_after_reset", {28'h0, arready, awready, wready, rvalid}, 32'he);
    n = 0;
    for (int k = 0; k < 4; k++) begin
      if (rvalid) n++;
      tick();
    end
    check("rstr_no_rvalid", 32'(n), 32'd0);
    do_read(32'h8000_0010, got_d, got_r, lat);
    check("rstr_followup_data", got_d, 32'hDEAD_BEEF);
    check("rstr_followup_lat", 32'(lat), 32'd2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/axi_lite_sram_slave.md
Name: axi_lite_sram_slave

Overview:
- AXI4-Lite responder (slave) backing-store memory: the far end of the IFU instruction-fetch port and the LSU load/store port.
- Independent read and write channel FSMs with a configurable response latency, so the core's valid/ready pipeline sees multi-cycle memory.
- One instance serves one initiator; arbitration between initiators is out of scope.

Parameters:
- ADDR_W, 32, address width
- DATA_W, 32, data width (fixed 32; wstrb is DATA_W/8)
- DEPTH_WORDS, 4096, number of 32-bit words stored
- BASE_ADDR, 32'h8000_0000, byte address of word 0
- READ_LAT, 2, cycles from AR handshake to rvalid assertion (>=1)
- WRITE_LAT, 2, cycles from AW+W both captured to bvalid assertion (>=1)

Ports:
- clk  input  1  clock
- rst  input  1  synchronous active-high reset
- araddr  input  32  read address
- arvalid  input  1  read address valid
- arready  output  1  read address accepted
- rdata  output  32  read data
- rresp  output  2  read response
- rvalid  output  1  read data valid
- rready  input  1  initiator accepts read data
- awaddr  input  32  write address
- awvalid  input  1  write address valid
- awready  output  1  write address accepted
- wdata  input  32  write data
- wstrb  input  4  byte enables
- wvalid  input  1  write data valid
- wready  output  1  write data accepted
- bresp  output  2  write response
- bvalid  output  1  write response valid
- bready  input  1  initiator accepts write response

Behaviour:
- Interface: one clock, clk; reset rst is synchronous and active-high.
- All outputs are registered.
- Reset values:
  - arready=0, awready=0, wready=0, rvalid=0, bvalid=0, rdata=0, rresp=0, bresp=0.
  - The ready signals go to 1 on the first cycle after rst deasserts.
  - Memory contents are not reset.
- Address decode:
  - index = (addr - BASE_ADDR) >> 2; addr[1:0] is ignored.
  - In range iff BASE_ADDR <= addr < BASE_ADDR + 4*DEPTH_WORDS.
  - Subtraction is 32-bit unsigned.
- Read FSM: R_IDLE, R_WAIT, R_RESP.
  - R_IDLE: arready=1. When arvalid&arready, capture araddr, load counter with READ_LAT-1, drop arready, go to R_WAIT.
  - R_WAIT: when the counter reaches 0, register rdata=mem[index], rresp=OKAY, rvalid=1, go to R_RESP.
  - Out-of-range read: rdata=0, rresp=SLVERR (2'b10).
  - READ_LAT=1: rvalid is high exactly one cycle after the AR handshake.
  - R_RESP: hold rdata, rresp and rvalid stable until rready. On rvalid&rready, rvalid=0, arready=1, go to R_IDLE.
  - No new AR is accepted before the R handshake completes; at most one read is outstanding.
- Write FSM: W_IDLE, W_WAIT, W_RESP.
  - W_IDLE: awready=1 and wready=1.
  - AW and W are captured independently; each ready drops after its own handshake.
  - Same-cycle AW and W is allowed.
  - Once both are captured, load counter with WRITE_LAT-1 and go to W_WAIT.
  - W_WAIT: when the counter reaches 0, commit the byte lanes with wstrb[i]=1 to mem[index], set bresp=OKAY, bvalid=1, go to W_RESP.
  - Out-of-range write: no memory change, bresp=SLVERR.
  - wstrb=0: no change, bresp=OKAY.
  - W_RESP: hold bvalid until bready. On the handshake, re-assert awready and wready and go to W_IDLE.
- Read/write collision:
  - A read sampling on the same edge that a write commits to the same word returns the pre-write data.
  - A read sampling any later cycle returns the new data.
- Reset mid-operation: both FSMs return to idle, outstanding transactions are dropped, and no response is issued.
  - A write whose commit edge coincides with rst asserted is not committed.
- rvalid and bvalid never drop without their handshake. rdata, rresp and bresp do not change while their valid is high.

Decomposition:
- Package npc_axi_pkg:
  - RESP_OKAY=2'b00, RESP_SLVERR=2'b10.
  - Enums rd_state_t {R_IDLE,R_WAIT,R_RESP} and wr_state_t {W_IDLE,W_WAIT,W_RESP}.
- One sub-module, axi_lat_counter.
  - Loadable down-counter with a done flag.
  - Instantiated twice, once per channel.

Test Plan:
- Reset then write: after rst, awaddr=0x8000_0010, wdata=0xDEADBEEF, wstrb=4'hF, same cycle -> bvalid rises 2 cycles after capture, bresp=0. Then read 0x8000_0010 -> rvalid 2 cycles after AR handshake, rdata=0xDEADBEEF, rresp=0.
- Byte strobe: word preloaded 0x11223344, write wdata=0xAABBCCDD, wstrb=4'b0101 -> readback 0x11BB33DD.
- Split AW/W: AW handed over 3 cycles before W -> awready low after AW, wready stays 1. Counter starts only after W capture, so bvalid comes 2 cycles after the W handshake.
- Backpressure: rready held 0 for 5 cycles -> rvalid, rdata and rresp stable for all 5 cycles, arready=0 throughout. Release rready -> arready=1 the next cycle.
- Out of range: araddr=0x7FFF_FFFC -> rresp=2'b10, rdata=0. Write to 0x8000_4000 (DEPTH 4096) -> bresp=2'b10, and word 0x8000_3FFC is unchanged.
- Reset mid-read: assert rst during R_WAIT -> rvalid never rises, all readies 0 during rst and 1 the cycle after. A subsequent read completes normally.
